// File: rtl/mac_pkg.sv
// Shared definitions for the matrix multiply sequencer.
//   state_e       : sequencer states (IDLE, MAC, WRITE, DONE)
//   addr_width()  : address width for a dimension, never below 1 bit
//   result_width(): accumulator / C element width for a given input width and K
//   DEF_*         : default geometry and the widths derived from it
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int addr_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // A K-term sum of full-width signed products needs clog2(K) guard bits.
  function automatic int result_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  localparam int DEF_M  = 4;
  localparam int DEF_K  = 4;
  localparam int DEF_N  = 4;
  localparam int DEF_DW = 32;
  localparam int DEF_RW = result_width(DEF_DW, DEF_K);
  localparam int DEF_MW = addr_width(DEF_M);
  localparam int DEF_KW = addr_width(DEF_K);
  localparam int DEF_NW = addr_width(DEF_N);

endpackage

// File: rtl/mac_seq_acc.sv
// Signed multiply-accumulate register.
//   clk, srst_i : clock, synchronous active-high reset
//   clr_i       : load zero (takes priority over en_i)
//   en_i        : add a_i * b_i (signed) into the accumulator
//   a_i, b_i    : signed two's complement operands, DW bits
//   acc_o       : accumulator, RW bits (RW > 2*DW)
module mac_seq_acc
  import mac_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW
) (
  input  logic          clk,
  input  logic          srst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [RW-1:0] acc_o
);

  logic signed [2*DW-1:0] prod;
  logic        [RW-1:0]   prod_ext;
  logic        [RW-1:0]   acc_q;

  assign prod     = $signed(a_i) * $signed(b_i);
  // Sign-extend the product into the guard bits before adding.
  assign prod_ext = {{(RW - 2*DW){prod[2*DW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (srst_i || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer computing C = A x B over an external matrix SRAM (combinational
// read, synchronous write). Each C element takes K MAC cycles (reads of
// A(i,k) and B(k,j)) followed by one WRITE cycle of the accumulated sum.
//   clk, reset        : clock, synchronous active-high reset
//   start / stop      : begin a run (IDLE only) / abort (MAC or WRITE only)
//   busy/done/aborted : status; done and aborted are one-cycle pulses
//   matrix_a_*, matrix_b_* : read enables, addresses, read data for A and B
//   matrix_c_we, row/col_addr_c, data_in_c : write port for C
// Memory-side outputs are Moore-decoded and all zero while idle, so the host
// can drive the shared memory lines whenever busy is low.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int K = DEF_K,
  parameter int N = DEF_N,
  parameter int DATA_WIDTH_INIT_MATRIX   = DEF_DW,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                stop,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic                                matrix_a_re,
  output logic [$clog2(M)-1:0]                row_addr_a,
  output logic [$clog2(K)-1:0]                col_addr_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
  output logic                                matrix_b_re,
  output logic [$clog2(K)-1:0]                row_addr_b,
  output logic [$clog2(N)-1:0]                col_addr_b,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
  output logic                                matrix_c_we,
  output logic [$clog2(M)-1:0]                row_addr_c,
  output logic [$clog2(N)-1:0]                col_addr_c,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c
);

  localparam int MW = $clog2(M);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);
  localparam logic [MW-1:0] I_LAST = MW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] J_LAST = NW'(N - 1);

  state_e        state_q, state_d;
  logic [MW-1:0] i_q, i_d;
  logic [KW-1:0] k_q, k_d;
  logic [NW-1:0] j_q, j_d;
  logic          aborted_q, aborted_d;
  logic          acc_clr, acc_en;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] acc;

  mac_seq_acc #(
    .DW (DATA_WIDTH_INIT_MATRIX),
    .RW (DATA_WIDTH_RESULT_MATRIX)
  ) u_acc (
    .clk    (clk),
    .srst_i (reset),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .a_i    (data_out_a),
    .b_i    (data_out_b),
    .acc_o  (acc)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    aborted_d = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (stop) begin
          // Partial sum is discarded; no write for this element.
          acc_clr   = 1'b1;
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          acc_en = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_WRITE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // The write itself is combinational from this state, so it happens
        // in this cycle whether or not stop is sampled.
        acc_clr = 1'b1;
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) begin
            i_d     = '0;
            state_d = ST_DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = ST_MAC;
          end
        end else begin
          j_d     = j_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      aborted_q <= aborted_d;
    end
  end

  logic in_mac, in_write;
  assign in_mac   = (state_q == ST_MAC);
  assign in_write = (state_q == ST_WRITE);

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign aborted     = aborted_q;
  assign matrix_a_re = in_mac;
  assign matrix_b_re = in_mac;
  assign row_addr_a  = in_mac ? i_q : '0;
  assign col_addr_a  = in_mac ? k_q : '0;
  assign row_addr_b  = in_mac ? k_q : '0;
  assign col_addr_b  = in_mac ? j_q : '0;
  assign matrix_c_we = in_write;
  assign row_addr_c  = in_write ? i_q : '0;
  assign col_addr_c  = in_write ? j_q : '0;
  assign data_in_c   = in_write ? acc : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl at default geometry (4x4x4, 32-bit inputs).
module tb_mac_seq_ctrl;

  localparam int RW = 66;
  localparam int LIMIT = 100;
  localparam logic [RW-1:0] SENT = {RW{1'b1}};

  logic clk = 1'b0;
  logic reset, start, stop;
  logic busy, done, aborted;
  logic matrix_a_re, matrix_b_re, matrix_c_we;
  logic [1:0] row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c;
  logic [31:0] data_out_a, data_out_b;
  logic [RW-1:0] data_in_c;

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .matrix_a_re (matrix_a_re),
    .row_addr_a  (row_addr_a),
    .col_addr_a  (col_addr_a),
    .data_out_a  (data_out_a),
    .matrix_b_re (matrix_b_re),
    .row_addr_b  (row_addr_b),
    .col_addr_b  (col_addr_b),
    .data_out_b  (data_out_b),
    .matrix_c_we (matrix_c_we),
    .row_addr_c  (row_addr_c),
    .col_addr_c  (col_addr_c),
    .data_in_c   (data_in_c)
  );

  // Matrix memory model: combinational read, synchronous write.
  logic [31:0]   mem_a [4][4];
  logic [31:0]   mem_b [4][4];
  logic [RW-1:0] mem_c [4][4];
  logic          clr_c = 1'b0;
  int            wr_total = 0;

  assign data_out_a = mem_a[row_addr_a][col_addr_a];
  assign data_out_b = mem_b[row_addr_b][col_addr_b];

  always @(posedge clk) begin
    if (clr_c) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          mem_c[r][c] <= SENT;
    end else if (matrix_c_we) begin
      mem_c[row_addr_c][col_addr_c] <= data_in_c;
      wr_total <= wr_total + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic outs_zero();
    return !(busy | done | aborted | matrix_a_re | matrix_b_re | matrix_c_we)
        && row_addr_a == 0 && col_addr_a == 0 && row_addr_b == 0
        && col_addr_b == 0 && row_addr_c == 0 && col_addr_c == 0
        && data_in_c == 0;
  endfunction

  // pattern 0: A=I, B[k][j]=4k+j; 1: all 32'h8000_0000; 2: A[i][k]=i-k, B[k][j]=j+1
  task automatic load(input int pat);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        case (pat)
          0: begin mem_a[r][c] = (r == c) ? 32'd1 : 32'd0; mem_b[r][c] = 32'(4*r + c); end
          1: begin mem_a[r][c] = 32'h8000_0000; mem_b[r][c] = 32'h8000_0000; end
          default: begin mem_a[r][c] = 32'(r - c); mem_b[r][c] = 32'(c + 1); end
        endcase
      end
  endtask

  task automatic clear_c();
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
  endtask

  // Starts a run and observes LIMIT cycles; cycle 1 is the first after the
  // start edge. Optional actions are applied during the given cycle.
  task automatic run(input int restart_at, input int stop_at, input int reset_at,
                     output int done_at, output int n_done, output int n_abort,
                     output int abort_at, output int n_wr, output logic rst_snap);
    int base;
    base = wr_total;
    done_at = -1; n_done = 0; n_abort = 0; abort_at = -1; rst_snap = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rel = 1; rel <= LIMIT; rel++) begin
      if (done)    begin n_done++; if (done_at < 0) done_at = rel; end
      if (aborted) begin n_abort++; abort_at = rel; end
      if (rel == reset_at + 1) rst_snap = outs_zero();
      start = (rel == restart_at);
      stop  = (rel == stop_at);
      reset = (rel == reset_at);
      tick();
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0;
    n_wr = wr_total - base;
  endtask

  typedef struct {
    string         name;
    int            run_id;
    int            ci;
    int            cj;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t          vecs [12];
  logic [RW-1:0] cres [3][4][4];

  initial begin
    int da, nd, na, aa, nw;
    logic snap;

    vecs[0]  = '{"id C00",   0, 0, 0, 66'd0};
    vecs[1]  = '{"id C12",   0, 1, 2, 66'd6};
    vecs[2]  = '{"id C21",   0, 2, 1, 66'd9};
    vecs[3]  = '{"id C33",   0, 3, 3, 66'd15};
    vecs[4]  = '{"min C00",  1, 0, 0, 66'd1 << 64};
    vecs[5]  = '{"min C23",  1, 2, 3, 66'd1 << 64};
    vecs[6]  = '{"min C33",  1, 3, 3, 66'd1 << 64};
    vecs[7]  = '{"sgn C00",  2, 0, 0, -66'sd6};
    vecs[8]  = '{"sgn C13",  2, 1, 3, -66'sd8};
    vecs[9]  = '{"sgn C22",  2, 2, 2, 66'd6};
    vecs[10] = '{"sgn C31",  2, 3, 1, 66'd12};
    vecs[11] = '{"sgn C02",  2, 0, 2, -66'sd18};

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    load(0);
    tick(); tick();
    reset = 1'b0;
    chk("reset outputs zero", 66'(outs_zero()), 66'd1);

    // Three full runs, results captured for the table.
    for (int p = 0; p < 3; p++) begin
      load(p);
      clear_c();
      run(0, 0, 0, da, nd, na, aa, nw, snap);
      chk($sformatf("run%0d done cycle", p), 66'(da), 66'd81);
      chk($sformatf("run%0d write count", p), 66'(nw), 66'd16);
      chk($sformatf("run%0d done pulses", p), 66'(nd), 66'd1);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          cres[p][r][c] = mem_c[r][c];
    end

    for (int v = 0; v < 12; v++)
      chk(vecs[v].name, cres[vecs[v].run_id][vecs[v].ci][vecs[v].cj], vecs[v].exp);

    // Identity run: every element 4i+j.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (cres[0][r][c] !== 66'(4*r + c)) begin
          n_vec++; n_bad++;
          $display("FAIL id full C%0d%0d: got %0h, expected %0h", r, c, cres[0][r][c], 4*r + c);
        end else n_vec++;

    // Stop during MAC k=2 of element (1,0): cycle 23, IDLE+aborted in 24.
    load(0);
    clear_c();
    run(0, 23, 0, da, nd, na, aa, nw, snap);
    chk("stop writes", 66'(nw), 66'd4);
    chk("stop C03", mem_c[0][3], 66'd3);
    chk("stop C10 untouched", mem_c[1][0], SENT);
    chk("stop aborted pulses", 66'(na), 66'd1);
    chk("stop aborted cycle", 66'(aa), 66'd24);
    chk("stop done pulses", 66'(nd), 66'd0);

    // Stop sampled in a WRITE cycle (element (0,1) at cycle 10): write lands.
    clear_c();
    run(0, 10, 0, da, nd, na, aa, nw, snap);
    chk("stop-in-write writes", 66'(nw), 66'd2);
    chk("stop-in-write C01", mem_c[0][1], 66'd1);
    chk("stop-in-write aborted cycle", 66'(aa), 66'd11);

    // Stop coincides with final WRITE (cycle 80): stop wins.
    clear_c();
    run(0, 80, 0, da, nd, na, aa, nw, snap);
    chk("final-stop writes", 66'(nw), 66'd16);
    chk("final-stop done pulses", 66'(nd), 66'd0);
    chk("final-stop aborted pulses", 66'(na), 66'd1);

    // start re-pulsed at cycle 10 is ignored.
    clear_c();
    run(10, 0, 0, da, nd, na, aa, nw, snap);
    chk("restart done cycle", 66'(da), 66'd81);
    chk("restart done pulses", 66'(nd), 66'd1);
    chk("restart writes", 66'(nw), 66'd16);

    // Reset in cycle 30, then a fresh full run.
    clear_c();
    run(0, 0, 30, da, nd, na, aa, nw, snap);
    chk("midrun reset outputs zero", 66'(snap), 66'd1);
    chk("midrun reset done pulses", 66'(nd), 66'd0);
    clear_c();
    run(0, 0, 0, da, nd, na, aa, nw, snap);
    chk("post-reset done cycle", 66'(da), 66'd81);
    chk("post-reset writes", 66'(nw), 66'd16);
    chk("post-reset C32", mem_c[3][2], 66'd14);

    // Idle: stop toggling with start low keeps everything quiet.
    for (int c = 0; c < 6; c++) begin
      stop = c[0];
      tick();
      chk($sformatf("idle stop toggle %0d", c), 66'(outs_zero()), 66'd1);
    end
    stop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
